// File: rtl/rv32i_exec_core_if.sv
// ---------------------------------------------------------------------------
// rv32i_exec_core_if
// Bundle of the decode/execute slice operands and registered results.
//   master : register-read side, drives opcode/func3/func7/imm_src/src1/src2
//            and observes the registered control and ALU outputs.
//   slave  : the execute slice itself.
// ---------------------------------------------------------------------------
interface rv32i_exec_core_if #(
  parameter int DATA_WIDTH = 32
);
  logic [6:0]            opcode;
  logic [2:0]            func3;
  logic [6:0]            func7;
  logic [11:0]           imm_src;
  logic [DATA_WIDTH-1:0] src1;
  logic [DATA_WIDTH-1:0] src2;

  logic                  branch;
  logic                  mem_read;
  logic                  mem_2_reg;
  logic                  mem_write;
  logic                  alu_src;
  logic                  reg_write;
  logic [3:0]            alu_ctrl;
  logic [DATA_WIDTH-1:0] imm_signed;
  logic [DATA_WIDTH-1:0] results;
  logic                  zero;

  modport master (
    output opcode, func3, func7, imm_src, src1, src2,
    input  branch, mem_read, mem_2_reg, mem_write, alu_src, reg_write,
           alu_ctrl, imm_signed, results, zero
  );

  modport slave (
    input  opcode, func3, func7, imm_src, src1, src2,
    output branch, mem_read, mem_2_reg, mem_write, alu_src, reg_write,
           alu_ctrl, imm_signed, results, zero
  );
endinterface

// File: rtl/rv32i_exec_core.sv
// ---------------------------------------------------------------------------
// rv32i_exec_core
// Registered decode-and-execute slice: decodes opcode/func3/func7 into
// datapath control, sign-extends the 12-bit immediate and computes the ALU
// result. Every output is registered, so latency is exactly one clk.
//
// Ports:
//   clk    : system clock, rising edge
//   rst    : synchronous active-high reset (zero loads 1, all else 0)
//   io_exe : rv32i_exec_core_if.slave (operands in, control/result out)
//
// Build option:
//   RV32I_ALU_SHIFT_EN - when defined, SLL/SRL/SRA are implemented; when not,
//                        those alu_ctrl codes still decode but give result 0.
// ---------------------------------------------------------------------------
module rv32i_exec_core #(
  parameter int DATA_WIDTH = 32
) (
  input logic                clk,
  input logic                rst,
  rv32i_exec_core_if.slave   io_exe
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  logic                  w_branch, w_mem_read, w_mem_2_reg, w_mem_write;
  logic                  w_alu_src, w_reg_write, w_valid_op;
  logic [3:0]            w_alu_ctrl, w_func_ctrl;
  logic                  w_is_rtype;
  logic [DATA_WIDTH-1:0] w_imm_signed, w_op_b, w_alu_res, w_result;
  logic [4:0]            w_shamt;

  logic                  r_branch, r_mem_read, r_mem_2_reg, r_mem_write;
  logic                  r_alu_src, r_reg_write, r_zero;
  logic [3:0]            r_alu_ctrl;
  logic [DATA_WIDTH-1:0] r_imm_signed, r_results;

  assign w_imm_signed = {{(DATA_WIDTH-12){io_exe.imm_src[11]}}, io_exe.imm_src};
  assign w_is_rtype   = (io_exe.opcode == OP_RTYPE);

  // func3 map shared by R-type and I-ALU; func7[5] only selects SUB for R-type
  always_comb begin
    w_func_ctrl = ALU_ADD;
    case (io_exe.func3)
      3'b000:  w_func_ctrl = (w_is_rtype && io_exe.func7[5]) ? ALU_SUB : ALU_ADD;
      3'b001:  w_func_ctrl = ALU_SLL;
      3'b010:  w_func_ctrl = ALU_SLT;
      3'b011:  w_func_ctrl = ALU_SLTU;
      3'b100:  w_func_ctrl = ALU_XOR;
      3'b101:  w_func_ctrl = io_exe.func7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  w_func_ctrl = ALU_OR;
      default: w_func_ctrl = ALU_AND;
    endcase
  end

  always_comb begin
    w_branch    = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_2_reg = 1'b0;
    w_mem_write = 1'b0;
    w_alu_src   = 1'b0;
    w_reg_write = 1'b0;
    w_alu_ctrl  = ALU_ADD;
    w_valid_op  = 1'b1;
    case (io_exe.opcode)
      OP_LOAD: begin
        w_mem_read  = 1'b1;
        w_mem_2_reg = 1'b1;
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
      end
      OP_STORE: begin
        w_mem_write = 1'b1;
        w_alu_src   = 1'b1;
      end
      OP_RTYPE: begin
        w_reg_write = 1'b1;
        w_alu_ctrl  = w_func_ctrl;
      end
      OP_IALU: begin
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
        w_alu_ctrl  = w_func_ctrl;
      end
      OP_BRANCH: begin
        w_branch   = 1'b1;
        w_alu_ctrl = ALU_SUB;
      end
      default: w_valid_op = 1'b0;
    endcase
  end

  assign w_op_b  = w_alu_src ? w_imm_signed : io_exe.src2;
  assign w_shamt = w_op_b[4:0];

  always_comb begin
    w_alu_res = '0;
    case (w_alu_ctrl)
      ALU_ADD:  w_alu_res = io_exe.src1 + w_op_b;
      ALU_SUB:  w_alu_res = io_exe.src1 - w_op_b;
      ALU_AND:  w_alu_res = io_exe.src1 & w_op_b;
      ALU_OR:   w_alu_res = io_exe.src1 | w_op_b;
      ALU_XOR:  w_alu_res = io_exe.src1 ^ w_op_b;
`ifdef RV32I_ALU_SHIFT_EN
      ALU_SLL:  w_alu_res = io_exe.src1 << w_shamt;
      ALU_SRL:  w_alu_res = io_exe.src1 >> w_shamt;
      ALU_SRA:  w_alu_res = $signed(io_exe.src1) >>> w_shamt;
`else
      ALU_SLL, ALU_SRL, ALU_SRA: w_alu_res = {{(DATA_WIDTH-5){1'b0}}, w_shamt & 5'b0};
`endif
      ALU_SLT:  w_alu_res = {{(DATA_WIDTH-1){1'b0}},
                             ($signed(io_exe.src1) < $signed(w_op_b))};
      ALU_SLTU: w_alu_res = {{(DATA_WIDTH-1){1'b0}}, (io_exe.src1 < w_op_b)};
      default:  w_alu_res = '0;
    endcase
  end

  // unknown opcodes decode to ADD with src2, so the result must be forced
  assign w_result = w_valid_op ? w_alu_res : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch     <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_2_reg  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_alu_src    <= 1'b0;
      r_reg_write  <= 1'b0;
      r_alu_ctrl   <= ALU_ADD;
      r_imm_signed <= '0;
      r_results    <= '0;
      r_zero       <= 1'b1;
    end else begin
      r_branch     <= w_branch;
      r_mem_read   <= w_mem_read;
      r_mem_2_reg  <= w_mem_2_reg;
      r_mem_write  <= w_mem_write;
      r_alu_src    <= w_alu_src;
      r_reg_write  <= w_reg_write;
      r_alu_ctrl   <= w_alu_ctrl;
      r_imm_signed <= w_imm_signed;
      r_results    <= w_result;
      r_zero       <= (w_result == '0);
    end
  end

  assign io_exe.branch     = r_branch;
  assign io_exe.mem_read   = r_mem_read;
  assign io_exe.mem_2_reg  = r_mem_2_reg;
  assign io_exe.mem_write  = r_mem_write;
  assign io_exe.alu_src    = r_alu_src;
  assign io_exe.reg_write  = r_reg_write;
  assign io_exe.alu_ctrl   = r_alu_ctrl;
  assign io_exe.imm_signed = r_imm_signed;
  assign io_exe.results    = r_results;
  assign io_exe.zero       = r_zero;

endmodule

// File: tb/tb_rv32i_exec_core.sv
// ---------------------------------------------------------------------------
// tb_rv32i_exec_core
// Scoreboard bench: the driver applies one operation per cycle and queues
// the reference model's expected outputs; the monitor pops one entry after
// every rising edge and compares it with the registered outputs.
// ---------------------------------------------------------------------------
module tb_rv32i_exec_core;

  typedef struct packed {
    logic [5:0]  ctrl;   // branch, mem_read, mem_2_reg, mem_write, alu_src, reg_write
    logic [3:0]  alu;
    logic [31:0] imm;
    logic [31:0] res;
    logic        z;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  rv32i_exec_core_if #(.DATA_WIDTH(32)) exe_if ();

  rv32i_exec_core #(.DATA_WIDTH(32)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .io_exe (exe_if)
  );

  always #5 clk = ~clk;

  // Reference model: behaviour straight from the instruction semantics.
  function automatic exp_t model(input logic r, input logic [6:0] op,
                                 input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [11:0] imm, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t        e;
    int          si;
    logic [31:0] ie, ob;
    int          sh;
    logic        valid;
    e = '0;
    if (r) begin
      e.z = 1'b1;
      return e;
    end
    si    = imm[11] ? int'(imm) - 4096 : int'(imm);
    ie    = 32'(si);
    e.imm = ie;
    valid = 1'b1;
    case (op)
      7'b0000011: e.ctrl = 6'b011011;
      7'b0100011: e.ctrl = 6'b000110;
      7'b0110011: e.ctrl = 6'b000001;
      7'b0010011: e.ctrl = 6'b000011;
      7'b1100011: begin e.ctrl = 6'b100000; e.alu = 4'd1; end
      default:    valid = 1'b0;
    endcase
    if (op == 7'b0110011 || op == 7'b0010011) begin
      case (f3)
        3'd0: e.alu = (op == 7'b0110011 && f7[5]) ? 4'd1 : 4'd0;
        3'd1: e.alu = 4'd5;
        3'd2: e.alu = 4'd8;
        3'd3: e.alu = 4'd9;
        3'd4: e.alu = 4'd4;
        3'd5: e.alu = f7[5] ? 4'd7 : 4'd6;
        3'd6: e.alu = 4'd3;
        default: e.alu = 4'd2;
      endcase
    end
    ob = e.ctrl[1] ? ie : b;
    sh = int'(ob % 32);
    case (e.alu)
      4'd0: e.res = a + ob;
      4'd1: e.res = a - ob;
      4'd2: e.res = a & ob;
      4'd3: e.res = a | ob;
      4'd4: e.res = a ^ ob;
`ifdef RV32I_ALU_SHIFT_EN
      4'd5: e.res = 32'(longint'(a) * (longint'(1) << sh));
      4'd6: e.res = 32'(longint'(a) / (longint'(1) << sh));
      4'd7: e.res = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
`else
      4'd5, 4'd6, 4'd7: e.res = 32'h0;
`endif
      4'd8: e.res = (int'(a) < int'(ob)) ? 32'h1 : 32'h0;
      4'd9: e.res = (longint'({32'h0, a}) < longint'({32'h0, ob})) ? 32'h1 : 32'h0;
      default: e.res = 32'h0;
    endcase
    if (!valid) e.res = 32'h0;
    e.z = (e.res == 32'h0);
    return e;
  endfunction

  task automatic drive(input logic r, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [11:0] imm,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    rst            = r;
    exe_if.opcode  = op;
    exe_if.func3   = f3;
    exe_if.func7   = f7;
    exe_if.imm_src = imm;
    exe_if.src1    = a;
    exe_if.src2    = b;
    exp_q.push_back(model(r, op, f3, f7, imm, a, b));
  endtask

  // Monitor: one registered result per rising edge.
  initial begin
    exp_t e, got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = '{ctrl: {exe_if.branch, exe_if.mem_read, exe_if.mem_2_reg,
                       exe_if.mem_write, exe_if.alu_src, exe_if.reg_write},
                alu: exe_if.alu_ctrl, imm: exe_if.imm_signed,
                res: exe_if.results, z: exe_if.zero};
        n_checks++;
        if (got !== e) begin
          n_errors++;
          $display("FAIL exec_out#%0d got ctrl=%b alu=%h imm=%h res=%h zero=%b exp ctrl=%b alu=%h imm=%h res=%h zero=%b",
                   n_checks, got.ctrl, got.alu, got.imm, got.res, got.z,
                   e.ctrl, e.alu, e.imm, e.res, e.z);
        end
      end
    end
  end

  initial begin
    logic [6:0] ops [5];
    logic [6:0] op, f7;
    logic [31:0] a, b;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011};
    exe_if.opcode  = '0;
    exe_if.func3   = '0;
    exe_if.func7   = '0;
    exe_if.imm_src = '0;
    exe_if.src1    = '0;
    exe_if.src2    = '0;

    // directed cases
    drive(1'b1, 7'b1111111, 3'd0, 7'h00, 12'h000, 32'h0, 32'h0);
    drive(1'b0, 7'b1111111, 3'd0, 7'h00, 12'h000, 32'h0, 32'h0);
    drive(1'b0, 7'b1111111, 3'd0, 7'h00, 12'h123, 32'h55, 32'h66);
    drive(1'b0, 7'b0000011, 3'd2, 7'h00, 12'h7FF, 32'h1000, 32'h0);
    drive(1'b0, 7'b0000011, 3'd2, 7'h00, 12'h800, 32'h2000, 32'h0);
    drive(1'b0, 7'b0100011, 3'd2, 7'h00, 12'hFFC, 32'h4, 32'hDEAD);
    drive(1'b0, 7'b0110011, 3'd0, 7'h20, 12'h000, 32'h5, 32'h7);
    drive(1'b0, 7'b0110011, 3'd5, 7'h20, 12'h000, 32'h8000_0000, 32'h4);
    drive(1'b0, 7'b0110011, 3'd5, 7'h00, 12'h000, 32'h8000_0000, 32'h4);
    drive(1'b0, 7'b0110011, 3'd1, 7'h00, 12'h000, 32'h0000_0003, 32'h21);
    drive(1'b0, 7'b0110011, 3'd2, 7'h00, 12'h000, 32'hFFFF_FFFF, 32'h1);
    drive(1'b0, 7'b0110011, 3'd3, 7'h00, 12'h000, 32'hFFFF_FFFF, 32'h1);
    drive(1'b0, 7'b0010011, 3'd0, 7'h20, 12'hFFF, 32'h1, 32'h0);
    drive(1'b0, 7'b1100011, 3'd0, 7'h00, 12'h000, 32'h1234, 32'h1234);
    drive(1'b0, 7'b1100011, 3'd0, 7'h00, 12'h000, 32'h1234, 32'h1235);
    drive(1'b1, 7'b0000011, 3'd2, 7'h00, 12'h7FF, 32'h1000, 32'h0);
    drive(1'b0, 7'b0000011, 3'd2, 7'h00, 12'h7FF, 32'h1000, 32'h0);

    // randomized back-to-back traffic
    for (int i = 0; i < 400; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 4)];
      f7 = ($urandom_range(0, 3) == 0) ? 7'($urandom) :
           ($urandom_range(0, 1) ? 7'h20 : 7'h00);
      a  = $urandom_range(0, 2) == 0 ? 32'($urandom_range(0, 40)) : $urandom;
      b  = $urandom_range(0, 3) == 0 ? a :
           ($urandom_range(0, 1) ? 32'($urandom_range(0, 40)) : $urandom);
      drive(($urandom_range(0, 29) == 0), op, 3'($urandom), f7, 12'($urandom), a, b);
    end

    @(negedge clk);
    @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain left=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
